// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: detects mispredicts, redirects fetch, queues corrected entries
// and drains them one per cycle into the BTB write port. Optional counters: BTB_UPD_STATS_EN.
module btb_update_ctrl #(
    parameter int TAG   = 27,
    parameter int PC    = 32,
    parameter int DEPTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               res_valid_in,
    output logic               res_ready_out,
    input  logic [PC-1:0]      res_pc_in,
    input  logic               res_taken_in,
    input  logic [PC-1:0]      res_target_in,
    input  logic [PC-1:0]      pred_target_in,
    output logic               redirect_out,
    output logic [PC-1:0]      redirect_pc_out,
    input  logic               wr_stall_in,
    output logic               update_out,
    output logic [PC-TAG-1:0]  index_out,
`ifdef BTB_UPD_STATS_EN
    output logic [31:0]        resolved_cnt_out,
    output logic [31:0]        mispred_cnt_out,
`endif
    output logic [PC-1:0]      new_pc_out
);

    localparam int IW = PC - TAG;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [IW-1:0] r_q_idx [DEPTH];
    logic [PC-1:0] r_q_pc  [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic [PC-1:0] r_redirect_pc;
    logic          r_redirect;
    logic          r_update;
    logic [IW-1:0] r_index;
    logic [PC-1:0] r_new_pc;

    logic [PC-1:0] w_next;
    logic [IW-1:0] w_idx;
    logic [PW-1:0] w_young_ptr;
    logic          w_accept;
    logic          w_mispred;
    logic          w_pop;
    logic          w_coal;
    logic          w_push;

    assign res_ready_out = (r_count != CNT_FULL);
    assign w_accept      = res_valid_in & res_ready_out;
    assign w_next        = res_taken_in ? res_target_in : (res_pc_in + PC'(4));
    assign w_mispred     = (w_next != pred_target_in);
    assign w_idx         = res_pc_in[PC-TAG+1:2];
    assign w_pop         = (r_count != '0) & ~wr_stall_in;
    assign w_young_ptr   = r_wr_ptr - PW'(1);

    // The youngest entry is only off-limits when it is also the head being popped now.
    assign w_coal = w_accept & w_mispred & (r_count != '0)
                  & (r_q_idx[w_young_ptr] == w_idx)
                  & ~(w_pop & (r_count == (PW+1)'(1)));
    assign w_push = w_accept & w_mispred & ~w_coal;

    always_ff @(posedge clk_in) begin
        if (w_coal)
            r_q_pc[w_young_ptr] <= w_next;
        if (w_push) begin
            r_q_idx[r_wr_ptr] <= w_idx;
            r_q_pc[r_wr_ptr]  <= w_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_update      <= 1'b0;
            r_index       <= '0;
            r_new_pc      <= '0;
        end else begin
            r_redirect <= w_accept & w_mispred;
            if (w_accept & w_mispred)
                r_redirect_pc <= w_next;
            r_update <= w_pop;
            if (w_pop) begin
                r_index  <= r_q_idx[r_rd_ptr];
                r_new_pc <= r_q_pc[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

`ifdef BTB_UPD_STATS_EN
    logic [31:0] r_resolved_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_resolved_cnt <= '0;
            r_mispred_cnt  <= '0;
        end else if (w_accept) begin
            r_resolved_cnt <= r_resolved_cnt + 32'd1;
            if (w_mispred)
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign resolved_cnt_out = r_resolved_cnt;
    assign mispred_cnt_out  = r_mispred_cnt;
`endif

    assign redirect_out    = r_redirect;
    assign redirect_pc_out = r_redirect_pc;
    assign update_out      = r_update;
    assign index_out       = r_index;
    assign new_pc_out      = r_new_pc;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: queue-based reference model checked every negedge,
// plus directed literal expectations from the scenario list.
module tb_btb_update_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic [31:0] pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        wr_stall;
    logic        update;
    logic [4:0]  index;
    logic [31:0] new_pc;
`ifdef BTB_UPD_STATS_EN
    logic [31:0] resolved_cnt;
    logic [31:0] mispred_cnt;
`endif

    btb_update_ctrl #(.TAG(27), .PC(32), .DEPTH(DEPTH)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .res_valid_in    (res_valid),
        .res_ready_out   (res_ready),
        .res_pc_in       (res_pc),
        .res_taken_in    (res_taken),
        .res_target_in   (res_target),
        .pred_target_in  (pred_target),
        .redirect_out    (redirect),
        .redirect_pc_out (redirect_pc),
        .wr_stall_in     (wr_stall),
        .update_out      (update),
        .index_out       (index),
`ifdef BTB_UPD_STATS_EN
        .resolved_cnt_out(resolved_cnt),
        .mispred_cnt_out (mispred_cnt),
`endif
        .new_pc_out      (new_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, got, exp, $time);
    endtask

    // Reference model: a plain queue of pending {index, pc} writes.
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic        e_redir = 0;
    logic [31:0] e_rpc   = 0;
    logic        e_upd   = 0;
    logic [4:0]  e_idx   = 0;
    logic [31:0] e_npc   = 0;
    logic [31:0] e_res_cnt = 0;
    logic [31:0] e_mis_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            e_redir = 0; e_rpc = 0; e_upd = 0; e_idx = 0; e_npc = 0;
            e_res_cnt = 0; e_mis_cnt = 0;
        end else begin
            logic        acc, pop, mis, merged;
            logic [31:0] nxt;
            logic [4:0]  idx;
            ent_t        t;
            acc = res_valid && (mq.size() < DEPTH);
            pop = (mq.size() > 0) && !wr_stall;
            nxt = res_taken ? res_target : res_pc + 32'd4;
            mis = (nxt != pred_target);
            idx = 5'((res_pc >> 2) & 32'h1f);
            merged = 0;
            e_upd = pop;
            if (pop) begin
                e_idx = mq[0].idx;
                e_npc = mq[0].pc;
            end
            e_redir = acc && mis;
            if (acc && mis) e_rpc = nxt;
            if (acc) e_res_cnt = e_res_cnt + 1;
            if (acc && mis) e_mis_cnt = e_mis_cnt + 1;
            if (acc && mis && mq.size() > 0 && mq[mq.size()-1].idx == idx
                && !(pop && mq.size() == 1)) begin
                t = mq[mq.size()-1];
                t.pc = nxt;
                mq[mq.size()-1] = t;
                merged = 1;
            end
            if (pop) void'(mq.pop_front());
            if (acc && mis && !merged) begin
                t.idx = idx;
                t.pc  = nxt;
                mq.push_back(t);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", {31'd0, res_ready}, {31'd0, mq.size() < DEPTH});
            check("model_redirect", {31'd0, redirect}, {31'd0, e_redir});
            if (e_redir) check("model_redirect_pc", redirect_pc, e_rpc);
            check("model_update", {31'd0, update}, {31'd0, e_upd});
            check("model_index", {27'd0, index}, {27'd0, e_idx});
            check("model_new_pc", new_pc, e_npc);
`ifdef BTB_UPD_STATS_EN
            check("model_resolved_cnt", resolved_cnt, e_res_cnt);
            check("model_mispred_cnt", mispred_cnt, e_mis_cnt);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tg, input logic [31:0] pd);
        res_valid   = v;
        res_pc      = pc;
        res_taken   = tk;
        res_target  = tg;
        pred_target = pd;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        wr_stall = 1'b0;
        idle();
        #1 rst_n = 1'b0;
        #1 chk_en = 1;
        step();
        check("reset_ready", {31'd0, res_ready}, 32'd1);
        check("reset_update", {31'd0, update}, 32'd0);
        check("reset_redirect", {31'd0, redirect}, 32'd0);
        check("reset_new_pc", new_pc, 32'd0);
        step();
        rst_n = 1'b1;
        step(); step();

        // 1: correct prediction
        drive(1, 32'h100, 1, 32'h200, 32'h200); step(); idle();
        check("t1_redirect", {31'd0, redirect}, 32'd0);
        step(); step(); step();
        check("t1_no_update", {31'd0, update}, 32'd0);

        // 2: taken mispredict
        drive(1, 32'h104, 1, 32'h300, 32'h108); step(); idle();
        check("t2_redirect", {31'd0, redirect}, 32'd1);
        check("t2_redirect_pc", redirect_pc, 32'h300);
        step();
        check("t2_update", {31'd0, update}, 32'd1);
        check("t2_index", {27'd0, index}, 32'd1);
        check("t2_new_pc", new_pc, 32'h300);
        step();
        check("t2_update_done", {31'd0, update}, 32'd0);
        check("t2_index_hold", {27'd0, index}, 32'd1);

        // 3: not-taken mispredict
        drive(1, 32'h108, 0, 32'h0, 32'h400); step(); idle();
        check("t3_redirect_pc", redirect_pc, 32'h10C);
        step();
        check("t3_update", {31'd0, update}, 32'd1);
        check("t3_index", {27'd0, index}, 32'd2);
        check("t3_new_pc", new_pc, 32'h10C);
        step();

        // 4: fill under stall, then drain in order
        wr_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h200 + 32'(4*k), 0, 32'h0, 32'h0);
            step();
        end
        drive(1, 32'h210, 0, 32'h0, 32'h0);
        check("t4_full_ready", {31'd0, res_ready}, 32'd0);
        step();
        check("t4_full_ready_hold", {31'd0, res_ready}, 32'd0);
        check("t4_no_update_stalled", {31'd0, update}, 32'd0);
        idle();
        wr_stall = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            check("t4_update", {31'd0, update}, 32'd1);
            check("t4_index", {27'd0, index}, 32'(k));
            check("t4_new_pc", new_pc, 32'h204 + 32'(4*k));
            step();
        end
        check("t4_drained", {31'd0, update}, 32'd0);

        // 5: coalesce two mispredicts at the same index
        wr_stall = 1'b1;
        drive(1, 32'h110, 1, 32'h500, 32'h0); step();
        check("t5_redirect_pc_a", redirect_pc, 32'h500);
        drive(1, 32'h110, 1, 32'h600, 32'h0); step(); idle();
        check("t5_redirect_pc_b", redirect_pc, 32'h600);
        check("t5_ready", {31'd0, res_ready}, 32'd1);
        wr_stall = 1'b0;
        step();
        check("t5_update", {31'd0, update}, 32'd1);
        check("t5_index", {27'd0, index}, 32'd4);
        check("t5_new_pc", new_pc, 32'h600);
        step();
        check("t5_single_update", {31'd0, update}, 32'd0);

        // 6: reset during drain
        wr_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h300 + 32'(4*k), 0, 32'h0, 32'h0);
            step();
        end
        idle();
        wr_stall = 1'b0;
        step();
        check("t6_update_pre", {31'd0, update}, 32'd1);
        check("t6_new_pc_pre", new_pc, 32'h304);
        #1 rst_n = 1'b0;
        #1;
        check("t6_update_async", {31'd0, update}, 32'd0);
        check("t6_new_pc_async", new_pc, 32'd0);
`ifdef BTB_UPD_STATS_EN
        check("t6_resolved_cnt", resolved_cnt, 32'd0);
        check("t6_mispred_cnt", mispred_cnt, 32'd0);
`endif
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_no_update", {31'd0, update}, 32'd0);
        end
        check("t6_ready", {31'd0, res_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
